hsv2rgb_fp: RTL
===============

Name: hsv2rgb_fp

Overview:
Converts one HSV pixel to RGB, all IEEE-754 single precision, over a multi-cycle sequence.
- Inverse of the RGB→HSV hue path: H in degrees [0,360), S and V in [0,1]; R, G, B out in [0,1].
- One shared combinational FP add/sub and multiply unit, time-multiplexed by an FSM.
- Valid/ready handshake on both sides; sits after the HSV-domain processing stage of the pixel pipeline.

Parameters:
- W, 32: float width; only 32 is supported.
- INV_SIXTY, 32'h3C888889: 1/60 as float; replaces division by 60.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  H/S/V inputs are valid.
- in_ready  out  1  block accepts inputs (IDLE only).
- h_in  in  32  hue, degrees.
- s_in  in  32  saturation.
- v_in  in  32  value.
- out_valid  out  1  result is valid; held until consumed.
- out_ready  in  1  downstream accepts the result.
- r_out  out  32  red.
- g_out  out  32  green.
- b_out  out  32  blue.

Behaviour:
- Reset (synchronous): state IDLE; out_valid=0; r_out/g_out/b_out=0; internal registers cleared. Applies mid-computation too: the in-flight pixel is discarded.
- in_ready = (state==IDLE). Inputs are captured on an edge where in_valid && in_ready.
- Sector select, done at capture by unsigned compare of the magnitude bits against 60/120/180/240/300:
  - k=0..5 = number of thresholds ≤ H; base = 60·k.
  - H with sign bit set (including -0) → H treated as +0, k=0.
  - H ≥ 360.0 (0x43B40000) → H treated as 0, k=0.
- FSM, one FP op per state, one cycle each:
  - IDLE → C1: C = V·S
  - C2: m = V − C
  - C3: hr = H − base
  - C4: f = hr·INV_SIXTY
  - C5: f' = f if k even, else f' = 1.0 − f. The cycle is spent in both cases.
  - C6: X = C·f'
  - C7: b = X + m
  - C8: a = C + m
  - → DONE
- On C8→DONE: outputs are registered and out_valid=1. Fixed latency: out_valid is high 8 edges after the accepting edge.
- Output mapping (R,G,B) by k:
  - 0: a,b,m
  - 1: b,a,m
  - 2: m,a,b
  - 3: m,b,a
  - 4: b,m,a
  - 5: a,m,b
- DONE: outputs and out_valid are stable while out_ready=0. On out_ready=1 → IDLE, out_valid=0 next cycle; outputs keep their last value.
- There is no accept in the same cycle as DONE; at least one IDLE cycle separates pixels.
- S=0 → C=0, X=0, so R=G=B=V exactly. V=0 → all outputs +0.
- NaN/Inf inputs: outputs unspecified, but the FSM still completes in 8 cycles.
- The arithmetic unit rounds exactly as the team's existing FP adder and multiplier; result accuracy is ±1 ulp per op.

Optional Feature:
HSV2RGB_SAT_EN
- Defined: each output is clamped at the DONE register. Sign bit set → 0x00000000; value > 1.0 → 0x3F800000. Latency unchanged.
- Undefined: raw results are passed through, so rounding may give values slightly above 1.0 or -0.

Decomposition:
- Package hsv2rgb_pkg holds:
  - state encoding: IDLE, C1..C8, DONE.
  - float constants: ONE 3F800000, F60 42700000, F120 42F00000, F180 43340000, F240 43700000, F300 43960000, F360 43B40000, INV_SIXTY.
  - the sector→channel select table.
- One sub-module, fp_arith_unit: combinational; inputs op {ADD, SUB, MUL}, operands a, b; output y. It wraps the existing FP adder and multiplier, and the FSM muxes its operands.

Test Plan:
- H=0x00000000, S=V=0x3F800000 → out_valid 8 edges after accept; R=3F800000, G=00000000, B=00000000.
- H=0x42F00000 (120), S=V=1.0 → G=3F800000, R=B=0.
- H=0x41F00000 (30), S=V=1.0 → R=3F800000, G=3F000000 ±1ulp, B=0. Repeat with H=0x43520000 (210): R=0, G=3F000000 ±1ulp, B=3F800000.
- S=0, V=0x3F000000, H=0x43480000 (200) → R=G=B=3F000000 exactly.
- Wrap cases: H=0x43B40000 (360) and H=0x80000000 (-0) each give the same result as H=0.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles → outputs and out_valid stable, in_ready=0.
  - Assert rst during C4 → next cycle out_valid=0, in_ready=1, outputs 0.

Source files
------------

// File: rtl/hsv2rgb_pkg.sv
// hsv2rgb_pkg: shared types, float constants and helpers for the HSV->RGB converter.
//   state_e      FSM encoding (idle, eight arithmetic steps, done)
//   fp_op_e      operation select for fp_arith_unit
//   ch_sel_e     which intermediate (a, b, m) drives an output channel
//   sector_sel() sector -> per-channel select table
//   sector_of()/hue_eff()/sector_base() hue sector decode done at capture
package hsv2rgb_pkg;

    typedef enum logic [3:0] {
        StIdle, StC1, StC2, StC3, StC4, StC5, StC6, StC7, StC8, StDone
    } state_e;

    typedef enum logic [1:0] {OpAdd, OpSub, OpMul} fp_op_e;

    typedef enum logic [1:0] {SelA, SelB, SelM} ch_sel_e;

    typedef struct packed {
        ch_sel_e r;
        ch_sel_e g;
        ch_sel_e b;
    } rgb_sel_t;

    localparam logic [31:0] ONE       = 32'h3F800000;
    localparam logic [31:0] F60       = 32'h42700000;
    localparam logic [31:0] F120      = 32'h42F00000;
    localparam logic [31:0] F180      = 32'h43340000;
    localparam logic [31:0] F240      = 32'h43700000;
    localparam logic [31:0] F300      = 32'h43960000;
    localparam logic [31:0] F360      = 32'h43B40000;
    localparam logic [31:0] INV_SIXTY = 32'h3C888889;

    // a = C + m (max), b = X + m (ramp), m = V - C (min)
    function automatic rgb_sel_t sector_sel(input logic [2:0] k);
        case (k)
            3'd0:    return '{r: SelA, g: SelB, b: SelM};
            3'd1:    return '{r: SelB, g: SelA, b: SelM};
            3'd2:    return '{r: SelM, g: SelA, b: SelB};
            3'd3:    return '{r: SelM, g: SelB, b: SelA};
            3'd4:    return '{r: SelB, g: SelM, b: SelA};
            default: return '{r: SelA, g: SelM, b: SelB};
        endcase
    endfunction

    function automatic logic [31:0] pick_ch(input ch_sel_e s, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] m);
        case (s)
            SelA:    return a;
            SelB:    return b;
            default: return m;
        endcase
    endfunction

    // Negative (incl. -0) and >= 360 hues fold to +0; positive floats order like unsigned ints.
    function automatic logic hue_wraps(input logic [31:0] h);
        return h[31] || (h[30:0] >= F360[30:0]);
    endfunction

    function automatic logic [31:0] hue_eff(input logic [31:0] h);
        return hue_wraps(h) ? 32'h0 : h;
    endfunction

    function automatic logic [2:0] sector_of(input logic [31:0] h);
        logic [2:0] k;
        k = 3'd0;
        if (!hue_wraps(h)) begin
            if (h[30:0] >= F60[30:0])  k = k + 3'd1;
            if (h[30:0] >= F120[30:0]) k = k + 3'd1;
            if (h[30:0] >= F180[30:0]) k = k + 3'd1;
            if (h[30:0] >= F240[30:0]) k = k + 3'd1;
            if (h[30:0] >= F300[30:0]) k = k + 3'd1;
        end
        return k;
    endfunction

    function automatic logic [31:0] sector_base(input logic [2:0] k);
        case (k)
            3'd0:    return 32'h0;
            3'd1:    return F60;
            3'd2:    return F120;
            3'd3:    return F180;
            3'd4:    return F240;
            default: return F300;
        endcase
    endfunction

endpackage

// File: rtl/hsv2rgb_fp_if.sv
// hsv2rgb_fp_if: pixel handshake bundle for hsv2rgb_fp.
//   in_valid/in_ready + h_in/s_in/v_in : HSV input channel
//   out_valid/out_ready + r_out/g_out/b_out : RGB output channel
//   master: upstream/downstream side (testbench or pipeline); slave: the converter.
interface hsv2rgb_fp_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] h_in;
    logic [31:0] s_in;
    logic [31:0] v_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] r_out;
    logic [31:0] g_out;
    logic [31:0] b_out;

    modport master (
        output in_valid, h_in, s_in, v_in, out_ready,
        input  in_ready, out_valid, r_out, g_out, b_out
    );

    modport slave (
        input  in_valid, h_in, s_in, v_in, out_ready,
        output in_ready, out_valid, r_out, g_out, b_out
    );
endinterface

// File: rtl/hsv2rgb_fp_arith_unit.sv
// fp_arith_unit: combinational single-precision add/sub/multiply shared by the converter FSM.
//   op : OpAdd, OpSub (a - b) or OpMul
//   a, b : operands; y : result
// Round-to-nearest-even; zero/subnormal inputs act as signed zero, underflow flushes to zero,
// overflow saturates to infinity. NaN/Inf inputs give unspecified results.
module fp_arith_unit
    import hsv2rgb_pkg::*;
(
    input  fp_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic [31:0]       add_y;
    logic [31:0]       mul_y;

    logic              ad_sa, ad_sb, ad_swap, ad_sign, ad_az, ad_bz;
    logic [7:0]        ad_ebig, ad_esml, ad_d;
    logic [26:0]       ad_mbig, ad_msml, ad_msh, ad_mask, ad_norm;
    logic [27:0]       ad_sum;
    logic signed [9:0] ad_e;
    logic [4:0]        ad_lz;
    logic              ad_up;
    logic [24:0]       ad_rnd;
    logic [22:0]       ad_frac;

    always_comb begin
        ad_sa   = a[31];
        ad_sb   = b[31] ^ (op == OpSub);
        ad_az   = (a[30:23] == 8'd0);
        ad_bz   = (b[30:23] == 8'd0);
        // Larger magnitude first so only the smaller operand is ever shifted.
        ad_swap = (b[30:0] > a[30:0]);
        ad_sign = ad_swap ? ad_sb : ad_sa;
        ad_ebig = ad_swap ? b[30:23] : a[30:23];
        ad_esml = ad_swap ? a[30:23] : b[30:23];
        ad_mbig = {1'b1, (ad_swap ? b[22:0] : a[22:0]), 3'b000};
        ad_msml = {1'b1, (ad_swap ? a[22:0] : b[22:0]), 3'b000};
        ad_d    = ad_ebig - ad_esml;
        ad_mask = '0;
        if (ad_d >= 8'd27) begin
            ad_msh = 27'd1;
        end else begin
            ad_mask = (27'd1 << ad_d) - 27'd1;
            ad_msh  = ad_msml >> ad_d;
            ad_msh[0] = ad_msh[0] | (|(ad_msml & ad_mask));
        end

        ad_lz   = 5'd0;
        ad_e    = $signed({2'b00, ad_ebig});
        if (ad_sa == ad_sb) begin
            ad_sum = {1'b0, ad_mbig} + {1'b0, ad_msh};
            if (ad_sum[27]) begin
                ad_norm = {ad_sum[27:2], ad_sum[1] | ad_sum[0]};
                ad_e    = ad_e + 10'sd1;
            end else begin
                ad_norm = ad_sum[26:0];
            end
        end else begin
            ad_sum = {1'b0, ad_mbig - ad_msh};
            for (int i = 0; i < 27; i++) begin
                if (ad_sum[i]) ad_lz = 5'(26 - i);
            end
            ad_norm = ad_sum[26:0] << ad_lz;
            ad_e    = ad_e - $signed({5'd0, ad_lz});
        end

        ad_up   = ad_norm[2] & (ad_norm[1] | ad_norm[0] | ad_norm[3]);
        ad_rnd  = {1'b0, ad_norm[26:3]} + {24'd0, ad_up};
        if (ad_rnd[24]) ad_e = ad_e + 10'sd1;
        ad_frac = ad_rnd[24] ? ad_rnd[23:1] : ad_rnd[22:0];

        if (ad_az && ad_bz) begin
            add_y = {ad_sa & ad_sb, 31'd0};
        end else if (ad_bz) begin
            add_y = a;
        end else if (ad_az) begin
            add_y = {ad_sb, b[30:0]};
        end else if (ad_sum == 28'd0) begin
            add_y = 32'd0;
        end else if (ad_e <= 10'sd0) begin
            add_y = {ad_sign, 31'd0};
        end else if (ad_e >= 10'sd255) begin
            add_y = {ad_sign, 8'hFF, 23'd0};
        end else begin
            add_y = {ad_sign, ad_e[7:0], ad_frac};
        end
    end

    logic              mu_sign, mu_zero, mu_g, mu_st, mu_up;
    logic [47:0]       mu_prod;
    logic [23:0]       mu_mant;
    logic [24:0]       mu_rnd;
    logic signed [9:0] mu_e;
    logic [22:0]       mu_frac;

    always_comb begin
        mu_sign = a[31] ^ b[31];
        mu_zero = (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
        mu_prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        mu_e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (mu_prod[47]) begin
            mu_mant = mu_prod[47:24];
            mu_g    = mu_prod[23];
            mu_st   = |mu_prod[22:0];
            mu_e    = mu_e + 10'sd1;
        end else begin
            mu_mant = mu_prod[46:23];
            mu_g    = mu_prod[22];
            mu_st   = |mu_prod[21:0];
        end
        mu_up   = mu_g & (mu_st | mu_mant[0]);
        mu_rnd  = {1'b0, mu_mant} + {24'd0, mu_up};
        if (mu_rnd[24]) mu_e = mu_e + 10'sd1;
        mu_frac = mu_rnd[24] ? mu_rnd[23:1] : mu_rnd[22:0];

        if (mu_zero || mu_e <= 10'sd0) begin
            mul_y = {mu_sign, 31'd0};
        end else if (mu_e >= 10'sd255) begin
            mul_y = {mu_sign, 8'hFF, 23'd0};
        end else begin
            mul_y = {mu_sign, mu_e[7:0], mu_frac};
        end
    end

    assign y = (op == OpMul) ? mul_y : add_y;

endmodule

// File: rtl/hsv2rgb_fp.sv
// hsv2rgb_fp: converts one HSV pixel (IEEE-754 single) to RGB over a fixed 8-step sequence
// through one shared fp_arith_unit.
//   clk, rst    : clock, synchronous active-high reset (drops any in-flight pixel)
//   bus (slave) : in_valid/in_ready/h_in/s_in/v_in in, out_valid/out_ready/r_out/g_out/b_out out
// Parameters: W float width (32 only), INV_SIXTY = 1/60 used in place of a divide.
// Build option: define HSV2RGB_SAT_EN to clamp each output into [+0, 1.0] when registered.
module hsv2rgb_fp
    import hsv2rgb_pkg::*;
#(
    parameter int unsigned W         = 32,
    parameter logic [31:0] INV_SIXTY = 32'h3C888889
) (
    input logic         clk,
    input logic         rst,
    hsv2rgb_fp_if.slave bus
);

    state_e       state_q, state_d;
    logic [W-1:0] h_q, h_d, s_q, s_d, v_q, v_d;
    logic [W-1:0] c_q, c_d, m_q, m_d, t_q, t_d;
    logic [W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [2:0]   k_q, k_d;

    fp_op_e       alu_op;
    logic [31:0]  alu_a, alu_b, alu_y;
    rgb_sel_t     sel;

    function automatic logic [31:0] out_fix(input logic [31:0] x);
`ifdef HSV2RGB_SAT_EN
        if (x[31]) return 32'h0;
        if (x[30:0] > ONE[30:0]) return ONE;
        return x;
`else
        return x;
`endif
    endfunction

    fp_arith_unit u_arith (
        .op (alu_op),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    assign sel = sector_sel(k_q);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        v_d     = v_q;
        k_d     = k_q;
        c_d     = c_q;
        m_d     = m_q;
        t_d     = t_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        alu_op  = OpAdd;
        alu_a   = c_q;
        alu_b   = m_q;

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    h_d     = hue_eff(bus.h_in);
                    k_d     = sector_of(bus.h_in);
                    s_d     = bus.s_in;
                    v_d     = bus.v_in;
                    state_d = StC1;
                end
            end
            StC1: begin  // C = V*S
                alu_op  = OpMul;
                alu_a   = v_q;
                alu_b   = s_q;
                c_d     = alu_y;
                state_d = StC2;
            end
            StC2: begin  // m = V - C
                alu_op  = OpSub;
                alu_a   = v_q;
                alu_b   = c_q;
                m_d     = alu_y;
                state_d = StC3;
            end
            StC3: begin  // hr = H - 60k
                alu_op  = OpSub;
                alu_a   = h_q;
                alu_b   = sector_base(k_q);
                t_d     = alu_y;
                state_d = StC4;
            end
            StC4: begin  // f = hr/60
                alu_op  = OpMul;
                alu_a   = t_q;
                alu_b   = INV_SIXTY;
                t_d     = alu_y;
                state_d = StC5;
            end
            StC5: begin  // odd sectors ramp down; even sectors keep f but still spend the cycle
                alu_op  = OpSub;
                alu_a   = ONE;
                alu_b   = t_q;
                t_d     = k_q[0] ? alu_y : t_q;
                state_d = StC6;
            end
            StC6: begin  // X = C*f'
                alu_op  = OpMul;
                alu_a   = c_q;
                alu_b   = t_q;
                t_d     = alu_y;
                state_d = StC7;
            end
            StC7: begin  // b = X + m
                alu_op  = OpAdd;
                alu_a   = t_q;
                alu_b   = m_q;
                t_d     = alu_y;
                state_d = StC8;
            end
            StC8: begin  // a = C + m, then route a/b/m to the channels
                alu_op  = OpAdd;
                alu_a   = c_q;
                alu_b   = m_q;
                r_d     = out_fix(pick_ch(sel.r, alu_y, t_q, m_q));
                g_d     = out_fix(pick_ch(sel.g, alu_y, t_q, m_q));
                b_d     = out_fix(pick_ch(sel.b, alu_y, t_q, m_q));
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            h_q     <= '0;
            s_q     <= '0;
            v_q     <= '0;
            k_q     <= '0;
            c_q     <= '0;
            m_q     <= '0;
            t_q     <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            s_q     <= s_d;
            v_q     <= v_d;
            k_q     <= k_d;
            c_q     <= c_d;
            m_q     <= m_d;
            t_q     <= t_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.r_out     = r_q;
    assign bus.g_out     = g_q;
    assign bus.b_out     = b_q;

endmodule
